hdlc_rx_deframer: RTL and testbench
===================================

HDLC_RX_DEFRAMER -- requirements
Module: hdlc_rx_deframer

Interface
REQ-001 Parameter MAX_BYTES, default 128: maximum data bytes per frame before overflow.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Rst  input  1  asynchronous, active-high reset.
REQ-004 RxEN  input  1  receiver enable.
REQ-005 Rx  input  1  serial line bit, one bit per Clk, LSB of each byte first; idle line is 1.
REQ-006 Rx_Data  output  8  last assembled data byte.
REQ-007 Rx_NewByte  output  1  one-cycle pulse: Rx_Data updated.
REQ-008 Rx_FlagDetect  output  1  one-cycle pulse: flag 01111110 received.
REQ-009 Rx_AbortDetect  output  1  one-cycle pulse: abort (0 then seven 1s) received.
REQ-010 Rx_ValidFrame  output  1  high while a frame is open.
REQ-011 Rx_EoF  output  1  one-cycle pulse: frame closed.
REQ-012 Rx_FrameError  output  1  frame closed with non-byte-aligned bit count or by RxEN drop; valid with Rx_EoF, held until next opening flag.
REQ-013 Rx_Overflow  output  1  sticky: more than MAX_BYTES bytes in the current frame.
REQ-014 Rx_FrameSize  output  8  bytes received in the current or last frame, saturating at MAX_BYTES.

Function
REQ-015 Let t be the cycle in which the final bit of a flag or abort pattern is on Rx.
- Rx_FlagDetect SHALL pulse in cycle t+2.
- Rx_AbortDetect SHALL pulse in cycle t+2.
REQ-016 Detection SHALL be bit-by-bit sliding, not byte-aligned.
- A 0 between two 1-runs may be the last bit of one pattern and the first bit of the next.
REQ-017 States: IDLE, OPEN, DATA.
- IDLE -> OPEN on flag detect.
- OPEN -> DATA on the first retained data bit.
- DATA -> IDLE on flag or abort detect.
- OPEN + flag detect SHALL stay in OPEN (shared/repeated flags; no empty frame, no Rx_EoF).
- OPEN + abort detect -> IDLE.
REQ-018 Rx_ValidFrame SHALL be high exactly in OPEN and DATA, rising in the same cycle as the opening Rx_FlagDetect and falling in the same cycle as the closing flag or abort detect.
REQ-019 Rx_EoF SHALL pulse in the cycle after Rx_ValidFrame falls, for every close from DATA or OPEN.
REQ-020 Zero removal in DATA: a 0 immediately following five consecutive retained 1s SHALL be discarded and SHALL not count toward byte alignment.
REQ-021 Flag and abort bits SHALL never be assembled into Rx_Data.
- A delay line of at least 8 bits between the detector and the byte assembler is required.
REQ-022 Byte assembly: every 8 retained bits SHALL load Rx_Data (first bit = bit 0) and pulse Rx_NewByte for one cycle.
- Rx_FrameSize SHALL increment on each Rx_NewByte, saturating at MAX_BYTES.
REQ-023 Rx_Overflow SHALL set on the (MAX_BYTES+1)th byte of a frame.
- Later bytes SHALL not pulse Rx_NewByte.
- Rx_Overflow SHALL clear only on the next opening flag.
REQ-024 Closing flag with a retained-bit count not a multiple of 8 SHALL set Rx_FrameError alongside Rx_EoF.
- The partial byte is discarded.
REQ-025 Abort during DATA SHALL:
- clear the partial byte;
- not set Rx_FrameError;
- leave Rx_FrameSize at the bytes completed.
REQ-026 RxEN low:
- Forces IDLE; no detect pulses while low.
- If a frame was open, Rx_ValidFrame falls that cycle, Rx_EoF pulses next cycle, and Rx_FrameError = 1.
REQ-027 Opening flag SHALL clear Rx_FrameSize, Rx_FrameError and Rx_Overflow in the same cycle Rx_ValidFrame rises.
REQ-028 Flag and abort detected in the same cycle is impossible by construction; if the history holds both, abort SHALL take priority.

Reset
REQ-029 Rst high SHALL asynchronously:
- force IDLE;
- clear the shift register, delay line and bit/byte counters;
- drive every output to 0, including Rx_Data = 8'h00 and Rx_FrameSize = 0.
REQ-030 Reset mid-frame SHALL produce no Rx_EoF.
- After release, the next flag is treated as an opening flag.
REQ-031 Shift history SHALL reset to all 1s, so no pattern is detected during the first 8 cycles after reset.

Verification
REQ-032 Idle 1s, flag, byte 0xA5, flag -> Rx_FlagDetect at t+2 of each flag, Rx_Data = 0xA5 with one Rx_NewByte, Rx_EoF one cycle after Rx_ValidFrame falls, Rx_FrameSize = 1, Rx_FrameError = 0.
REQ-033 Byte 0x3E sent as 0,1,1,1,1,1,0(inserted),0,0 -> stuffed zero removed, Rx_Data = 0x3E (value with bits 1-5 set), no flag detected.
REQ-034 Flag, 12 data bits, flag -> Rx_EoF with Rx_FrameError = 1, exactly one Rx_NewByte.
REQ-035 Flag, 2 bytes, 0 followed by seven 1s -> Rx_AbortDetect at t+2, Rx_ValidFrame falls, Rx_EoF next cycle, Rx_FrameSize = 2, Rx_FrameError = 0.
REQ-036 Flag, 129 bytes, flag -> 128 Rx_NewByte pulses, Rx_Overflow = 1 from the 129th byte, Rx_FrameSize = 128.
REQ-037 Three back-to-back flags, byte, flag -> single frame, one Rx_EoF; Rst pulse mid-frame -> all outputs 0 immediately, no Rx_EoF.

Source files
------------

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: sliding flag/abort detection, zero de-stuffing, byte assembly, frame status.
// Detect pulses 2 cycles after the last pattern bit; data bits pass through the 8-bit history as a delay line.
module hdlc_rx_deframer #(
   parameter int MAX_BYTES = 128
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       RxEN,
   input  logic       Rx,
   output logic [7:0] Rx_Data,
   output logic       Rx_NewByte,
   output logic       Rx_FlagDetect,
   output logic       Rx_AbortDetect,
   output logic       Rx_ValidFrame,
   output logic       Rx_EoF,
   output logic       Rx_FrameError,
   output logic       Rx_Overflow,
   output logic [7:0] Rx_FrameSize
);
   localparam logic [7:0] SIZE_MAX  = 8'(MAX_BYTES);
   localparam logic [7:0] FLAG_PAT  = 8'h7E;
   localparam logic [7:0] ABORT_PAT = 8'hFE;

   typedef enum logic [1:0] {IDLE = 2'd0, OPEN = 2'd1, DATA = 2'd2} state_t;
   state_t state, state_nxt;

   // hist[7] is the newest line bit, hist[0] the oldest and the next one offered to the assembler
   logic [7:0] hist;
   logic [7:0] byte_sr;
   logic [7:0] byte_nxt;
   logic [2:0] skip;
   logic [2:0] bit_cnt;
   logic [2:0] ones;
   logic       flag_q;
   logic       abort_q;
   logic       close_q;
   logic       flag_hit;
   logic       abort_hit;
   logic       take_bit;
   logic       frame_close;
   logic       drop;
   logic       stuffed;
   logic       keep;

   assign abort_hit = RxEN && (hist == ABORT_PAT);
   assign flag_hit  = RxEN && (hist == FLAG_PAT) && !abort_hit;
   assign drop      = !RxEN && (state != IDLE);
   assign stuffed   = take_bit && (ones == 3'd5) && !hist[0];
   assign keep      = take_bit && !stuffed;
   assign byte_nxt  = {hist[0], byte_sr[7:1]};

   assign Rx_FlagDetect  = flag_q && RxEN;
   assign Rx_AbortDetect = abort_q && RxEN;
   assign Rx_ValidFrame  = (state != IDLE) && RxEN;

   always_comb begin
      state_nxt   = state;
      take_bit    = 1'b0;
      frame_close = 1'b0;
      if (!RxEN) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (flag_hit) state_nxt = OPEN;
            end
            OPEN: begin
               if (abort_hit) begin
                  state_nxt   = IDLE;
                  frame_close = 1'b1;
               end else if (!flag_hit && skip == 3'd0) begin
                  take_bit  = 1'b1;
                  state_nxt = DATA;
               end
            end
            DATA: begin
               if (abort_hit || flag_hit) begin
                  state_nxt   = IDLE;
                  frame_close = 1'b1;
               end else begin
                  take_bit = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         hist          <= 8'hFF;
         byte_sr       <= 8'h00;
         skip          <= 3'd0;
         bit_cnt       <= 3'd0;
         ones          <= 3'd0;
         flag_q        <= 1'b0;
         abort_q       <= 1'b0;
         close_q       <= 1'b0;
         Rx_Data       <= 8'h00;
         Rx_NewByte    <= 1'b0;
         Rx_EoF        <= 1'b0;
         Rx_FrameError <= 1'b0;
         Rx_Overflow   <= 1'b0;
         Rx_FrameSize  <= 8'd0;
      end else begin
         hist       <= RxEN ? {Rx, hist[7:1]} : 8'hFF;
         flag_q     <= flag_hit;
         abort_q    <= abort_hit;
         close_q    <= frame_close;
         Rx_EoF     <= close_q || drop;
         Rx_NewByte <= 1'b0;

         // the seven remaining flag bits still sit in hist and must not reach the assembler
         if (flag_hit)           skip <= 3'd7;
         else if (!RxEN)         skip <= 3'd0;
         else if (skip != 3'd0)  skip <= skip - 3'd1;

         if (flag_hit || abort_hit || !RxEN) begin
            ones    <= 3'd0;
            bit_cnt <= 3'd0;
            byte_sr <= 8'h00;
         end else if (stuffed) begin
            ones <= 3'd0;
         end else if (keep) begin
            ones    <= hist[0] ? ones + {2'b00, (ones != 3'd7)} : 3'd0;
            byte_sr <= byte_nxt;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               if (Rx_FrameSize == SIZE_MAX) begin
                  Rx_Overflow <= 1'b1;
               end else begin
                  Rx_Data      <= byte_nxt;
                  Rx_NewByte   <= 1'b1;
                  Rx_FrameSize <= Rx_FrameSize + 8'd1;
               end
            end
         end

         if (drop || (frame_close && flag_hit && bit_cnt != 3'd0))
            Rx_FrameError <= 1'b1;

         if (state == IDLE && state_nxt == OPEN) begin
            Rx_FrameSize  <= 8'd0;
            Rx_FrameError <= 1'b0;
            Rx_Overflow   <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Bench for hdlc_rx_deframer: bit streams built from frames, expectations from a frame-level model.
module tb_hdlc_rx_deframer;
   logic       Clk = 1'b0;
   logic       Rst, RxEN, Rx;
   logic [7:0] Rx_Data, Rx_FrameSize;
   logic       Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame;
   logic       Rx_EoF, Rx_FrameError, Rx_Overflow;

   hdlc_rx_deframer #(.MAX_BYTES(128)) dut (
      .Clk(Clk), .Rst(Rst), .RxEN(RxEN), .Rx(Rx),
      .Rx_Data(Rx_Data), .Rx_NewByte(Rx_NewByte), .Rx_FlagDetect(Rx_FlagDetect),
      .Rx_AbortDetect(Rx_AbortDetect), .Rx_ValidFrame(Rx_ValidFrame), .Rx_EoF(Rx_EoF),
      .Rx_FrameError(Rx_FrameError), .Rx_Overflow(Rx_Overflow), .Rx_FrameSize(Rx_FrameSize)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;
   bit bits_q[$];
   bit en_q[$];
   bit cur_en = 1'b1;
   int sc = 0;
   byte unsigned exp_bytes[$];
   byte unsigned obs_bytes[$];
   bit exp_flag[], exp_abort[], exp_valid[], exp_eof[];
   int exp_err[], exp_size[], exp_ovf[];

   task automatic check(input string tag, input int cyc, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic clear_stream();
      bits_q.delete();
      en_q.delete();
      cur_en = 1'b1;
      sc = 0;
   endtask

   task automatic add_bit(input bit b);
      bits_q.push_back(b);
      en_q.push_back(cur_en);
   endtask

   task automatic add_ones(input int n);
      for (int i = 0; i < n; i++) add_bit(1'b1);
   endtask

   task automatic add_flag();
      add_bit(1'b0); add_ones(6); add_bit(1'b0); sc = 0;
   endtask

   // flag sharing its leading zero with the previous flag's trailing zero
   task automatic add_shared_flag();
      add_ones(6); add_bit(1'b0); sc = 0;
   endtask

   task automatic add_abort();
      add_bit(1'b0); add_ones(7); sc = 0;
   endtask

   task automatic add_dbit(input bit b);
      add_bit(b);
      if (b) begin
         sc++;
         if (sc == 5) begin add_bit(1'b0); sc = 0; end
      end else begin
         sc = 0;
      end
   endtask

   task automatic add_byte(input byte unsigned v);
      for (int i = 0; i < 8; i++) add_dbit(v[i]);
   endtask

   function automatic bit eff(input int k);
      if (k < 0) return 1'b1;
      return en_q[k] ? bits_q[k] : 1'b1;
   endfunction

   // frame content = line bits after the opening pattern up to the bit before the closing pattern
   task automatic close_frame(input int t, input int ds, input bit by_flag, input int ecyc);
      bit raw[$];
      int run = 0;
      int nbytes;
      byte unsigned v;
      for (int k = ds; k <= t - 8; k++) begin
         if (run == 5 && !bits_q[k]) begin
            run = 0;
         end else begin
            raw.push_back(bits_q[k]);
            run = bits_q[k] ? run + 1 : 0;
         end
      end
      nbytes = raw.size() / 8;
      for (int j = 0; j < nbytes && j < 128; j++) begin
         v = 8'h00;
         for (int i = 0; i < 8; i++) v[i] = raw[j*8 + i];
         exp_bytes.push_back(v);
      end
      exp_eof[ecyc]  = 1'b1;
      exp_err[ecyc]  = (by_flag && (raw.size() % 8 != 0)) ? 1 : 0;
      exp_size[ecyc] = (nbytes > 128) ? 128 : nbytes;
      exp_ovf[ecyc]  = (nbytes > 128) ? 1 : 0;
   endtask

   task automatic build_model();
      int n = bits_q.size();
      bit open = 1'b0;
      int ds = 0;
      exp_flag = new[n + 4]; exp_abort = new[n + 4]; exp_valid = new[n + 4];
      exp_eof = new[n + 4]; exp_err = new[n + 4]; exp_size = new[n + 4]; exp_ovf = new[n + 4];
      exp_bytes.delete();
      for (int c = 0; c < n; c++) begin
         logic [7:0] w;
         bit en_n;
         int t;
         if (!en_q[c] && open) begin
            open = 1'b0;
            exp_eof[c+1] = 1'b1; exp_err[c+1] = 1; exp_size[c+1] = 0; exp_ovf[c+1] = 0;
         end
         exp_valid[c] = open;
         if (en_q[c] && c >= 1) begin
            t = c - 1;
            for (int i = 0; i < 8; i++) w[i] = eff(t - 7 + i);
            en_n = (c + 1 < n) ? en_q[c+1] : 1'b1;
            if (w == 8'hFE) begin
               exp_abort[c+1] = en_n;
               if (open) begin close_frame(t, ds, 1'b0, c + 2); open = 1'b0; end
            end else if (w == 8'h7E) begin
               exp_flag[c+1] = en_n;
               if (!open) begin
                  open = 1'b1; ds = t + 1;
               end else if (t - 8 < ds) begin
                  ds = t + 1;
               end else begin
                  close_frame(t, ds, 1'b1, c + 2); open = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic run_stream(input string name);
      int n = bits_q.size();
      build_model();
      obs_bytes.delete();
      Rst = 1'b1; RxEN = 1'b1; Rx = 1'b1;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Rst = 1'b0;
      for (int c = 0; c < n; c++) begin
         @(posedge Clk);
         #1;
         Rx = bits_q[c];
         RxEN = en_q[c];
         #1;
         check({name, ".flag"},  c, Rx_FlagDetect,  exp_flag[c]);
         check({name, ".abort"}, c, Rx_AbortDetect, exp_abort[c]);
         check({name, ".valid"}, c, Rx_ValidFrame,  exp_valid[c]);
         check({name, ".eof"},   c, Rx_EoF,         exp_eof[c]);
         if (exp_eof[c]) begin
            check({name, ".err"},  c, Rx_FrameError, exp_err[c]);
            check({name, ".size"}, c, Rx_FrameSize,  exp_size[c]);
            check({name, ".ovf"},  c, Rx_Overflow,   exp_ovf[c]);
         end
         if (Rx_NewByte) obs_bytes.push_back(Rx_Data);
      end
      check({name, ".nbytes"}, n, obs_bytes.size(), exp_bytes.size());
      for (int i = 0; i < exp_bytes.size() && i < obs_bytes.size(); i++)
         check({name, ".byte"}, i, obs_bytes[i], exp_bytes[i]);
   endtask

   task automatic check_all_zero(input string name);
      check({name, ".data"},  -1, Rx_Data,        8'h00);
      check({name, ".nb"},    -1, Rx_NewByte,     1'b0);
      check({name, ".flag"},  -1, Rx_FlagDetect,  1'b0);
      check({name, ".abort"}, -1, Rx_AbortDetect, 1'b0);
      check({name, ".valid"}, -1, Rx_ValidFrame,  1'b0);
      check({name, ".eof"},   -1, Rx_EoF,         1'b0);
      check({name, ".err"},   -1, Rx_FrameError,  1'b0);
      check({name, ".ovf"},   -1, Rx_Overflow,    1'b0);
      check({name, ".size"},  -1, Rx_FrameSize,   8'd0);
   endtask

   initial begin
      int nb;
      Rst = 1'b1; RxEN = 1'b1; Rx = 1'b1;
      #1;
      check_all_zero("rst");

      clear_stream(); add_ones(10); add_flag(); add_byte(8'hA5); add_flag(); add_ones(12);
      run_stream("a5");
      check("a5.value", 0, (obs_bytes.size() > 0) ? obs_bytes[0] : 8'h00, 8'hA5);

      clear_stream(); add_ones(10); add_flag(); add_byte(8'h3E); add_flag(); add_ones(12);
      run_stream("stuff");
      check("stuff.value", 0, (obs_bytes.size() > 0) ? obs_bytes[0] : 8'h00, 8'h3E);

      clear_stream(); add_ones(10); add_flag();
      for (int i = 0; i < 12; i++) add_dbit(1'($urandom_range(0, 1)));
      add_flag(); add_ones(12);
      run_stream("bits12");

      clear_stream(); add_ones(10); add_flag();
      add_byte(8'($urandom)); add_byte(8'($urandom)); add_abort(); add_ones(12);
      run_stream("abort");

      clear_stream(); add_ones(10); add_flag();
      for (int i = 0; i < 129; i++) add_byte(8'($urandom));
      add_flag(); add_ones(12);
      run_stream("ovf");

      clear_stream(); add_ones(10); add_flag(); add_flag(); add_flag();
      add_byte(8'($urandom)); add_flag(); add_ones(12);
      run_stream("b2b");

      clear_stream(); add_ones(6); add_bit(1'b0); add_ones(12);
      run_stream("post_rst");

      clear_stream(); add_ones(10); add_flag(); add_ones(3);
      cur_en = 1'b0; add_ones(2); add_flag(); add_ones(15);
      cur_en = 1'b1; add_ones(12); add_flag(); add_byte(8'h81); add_flag(); add_ones(12);
      run_stream("rxen");

      clear_stream();
      for (int f = 0; f < 8; f++) begin
         add_ones($urandom_range(2, 10));
         add_flag();
         if ($urandom_range(0, 2) == 0) add_shared_flag();
         if ($urandom_range(0, 2) == 0) add_flag();
         nb = $urandom_range(0, 4);
         case ($urandom_range(0, 2))
            0: begin for (int i = 0; i < nb; i++) add_byte(8'($urandom)); add_flag(); end
            1: begin for (int i = 0; i < nb; i++) add_byte(8'($urandom)); add_abort(); end
            default: begin
               for (int i = 0; i < $urandom_range(1, 20); i++) add_dbit(1'($urandom_range(0, 1)));
               add_flag();
            end
         endcase
      end
      add_ones(12);
      run_stream("rand");

      clear_stream(); add_ones(10); add_flag(); add_byte(8'h5A); add_byte(8'hC3); add_byte(8'h00);
      Rst = 1'b1; RxEN = 1'b1; Rx = 1'b1;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Rst = 1'b0;
      for (int c = 0; c < bits_q.size(); c++) begin
         @(posedge Clk);
         #1;
         Rx = bits_q[c];
      end
      @(posedge Clk);
      #1;
      check("mid.valid_before", 0, Rx_ValidFrame, 1'b1);
      #1;
      Rst = 1'b1;
      #1;
      check_all_zero("mid");
      @(negedge Clk);
      Rst = 1'b0; Rx = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(posedge Clk);
         #2;
         check("mid.no_eof", c, Rx_EoF, 1'b0);
         check("mid.no_valid", c, Rx_ValidFrame, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
